// File: rtl/trap_sequencer.sv
// rtl/trap_sequencer.sv - machine-mode trap/mret sequencer between commit, CSR file and fetch
module trap_sequencer #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_valid,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic              inst_ecall,
    input  logic              inst_ebreak,
    input  logic              inst_mret,
    input  logic              clint_mtip,
    input  logic              mstatus_mie,
    input  logic              mie_mtie,
    input  logic [DATA_W-1:0] mtvec_in,
    input  logic [ADDR_W-1:0] mepc_in,
    input  logic              bus_busy,
    input  logic              redirect_ready,
    output logic              inst_kill,
    output logic              pipe_hold,
    output logic              trap_we,
    output logic [ADDR_W-1:0] trap_epc,
    output logic [DATA_W-1:0] trap_cause,
    output logic              ret_we,
    output logic              redirect_valid,
    output logic [ADDR_W-1:0] redirect_pc
);

    typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_SAVE, S_JUMP} state_t;

    localparam logic [DATA_W-1:0] IRQ_CAUSE = {1'b1, {(DATA_W-4){1'b0}}, 3'b111};

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_epc;
    logic [DATA_W-1:0] r_cause;
    logic              r_is_ret;

    logic              w_irq;
    logic              w_trap;
    logic              w_ret;
    logic [DATA_W-1:0] w_cause;
    logic [ADDR_W-1:0] w_base;
    logic              w_vectored;
    logic [ADDR_W-1:0] w_trap_pc;

    // An interrupt outranks any flag on the committing instruction; that instruction re-executes later.
    assign w_irq      = clint_mtip & mstatus_mie & mie_mtie;
    assign w_trap     = inst_valid & (w_irq | inst_ecall | inst_ebreak);
    assign w_ret      = inst_valid & inst_mret & ~w_trap;
    assign w_cause    = w_irq ? IRQ_CAUSE : (inst_ecall ? DATA_W'(11) : DATA_W'(3));
    assign w_base     = ADDR_W'(mtvec_in) & ~ADDR_W'(3);
    assign w_vectored = (mtvec_in[1:0] == 2'b01) & r_cause[DATA_W-1];
    assign w_trap_pc  = w_vectored ? (w_base + ADDR_W'({r_cause[5:0], 2'b00})) : w_base;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_epc    <= '0;
            r_cause  <= '0;
            r_is_ret <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE) begin
                if (w_trap) begin
                    r_epc    <= inst_addr;
                    r_cause  <= w_cause;
                    r_is_ret <= 1'b0;
                end else if (w_ret) begin
                    r_is_ret <= 1'b1;
                end
            end else if (r_state == S_JUMP && redirect_ready) begin
                r_is_ret <= 1'b0;
            end
        end
    end

    always_comb begin
        w_next         = r_state;
        inst_kill      = 1'b0;
        pipe_hold      = (r_state != S_IDLE);
        trap_we        = 1'b0;
        trap_epc       = '0;
        trap_cause     = '0;
        ret_we         = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        case (r_state)
            S_IDLE: begin
                inst_kill = w_trap;
                if (w_trap)     w_next = bus_busy ? S_DRAIN : S_SAVE;
                else if (w_ret) w_next = S_JUMP;
            end
            S_DRAIN: begin
                if (!bus_busy) w_next = S_SAVE;
            end
            S_SAVE: begin
                trap_we    = 1'b1;
                trap_epc   = r_epc;
                trap_cause = r_cause;
                w_next     = S_JUMP;
            end
            S_JUMP: begin
                redirect_valid = 1'b1;
                redirect_pc    = r_is_ret ? mepc_in : w_trap_pc;
                ret_we         = r_is_ret & redirect_ready;
                if (redirect_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_trap_sequencer.sv
// tb/tb_trap_sequencer.sv - vector table plus directed multi-cycle sequences for trap_sequencer
module tb_trap_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_valid, inst_ecall, inst_ebreak, inst_mret;
    logic [63:0] inst_addr;
    logic        clint_mtip, mstatus_mie, mie_mtie;
    logic [63:0] mtvec_in, mepc_in;
    logic        bus_busy, redirect_ready;
    logic        inst_kill, pipe_hold, trap_we, ret_we, redirect_valid;
    logic [63:0] trap_epc, trap_cause, redirect_pc;

    int total = 0;
    int bad   = 0;

    localparam logic [63:0] IRQ = 64'h8000_0000_0000_0007;

    trap_sequencer #(.DATA_W(64), .ADDR_W(64)) dut (
        .clk(clk), .rst(rst),
        .inst_valid(inst_valid), .inst_addr(inst_addr),
        .inst_ecall(inst_ecall), .inst_ebreak(inst_ebreak), .inst_mret(inst_mret),
        .clint_mtip(clint_mtip), .mstatus_mie(mstatus_mie), .mie_mtie(mie_mtie),
        .mtvec_in(mtvec_in), .mepc_in(mepc_in),
        .bus_busy(bus_busy), .redirect_ready(redirect_ready),
        .inst_kill(inst_kill), .pipe_hold(pipe_hold),
        .trap_we(trap_we), .trap_epc(trap_epc), .trap_cause(trap_cause),
        .ret_we(ret_we), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic        valid, ecall, ebreak, mret, mtip, mie, mtie;
        logic [63:0] addr, mtvec, mepc;
        logic        kill;
        int          kind;   // 0 none, 1 trap, 2 mret
        logic [63:0] cause, pc;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic clear_inputs();
        inst_valid  = 1'b0; inst_ecall = 1'b0; inst_ebreak = 1'b0; inst_mret = 1'b0;
        clint_mtip  = 1'b0; mstatus_mie = 1'b0; mie_mtie = 1'b0;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, ".kill"},  64'(inst_kill), 64'd0);
        chk({nm, ".hold"},  64'(pipe_hold), 64'd0);
        chk({nm, ".twe"},   64'(trap_we), 64'd0);
        chk({nm, ".tepc"},  trap_epc, 64'd0);
        chk({nm, ".tcause"}, trap_cause, 64'd0);
        chk({nm, ".rwe"},   64'(ret_we), 64'd0);
        chk({nm, ".rv"},    64'(redirect_valid), 64'd0);
        chk({nm, ".rpc"},   redirect_pc, 64'd0);
    endtask

    // Caller is at the negedge of the event cycle; walks SAVE, JUMP (ready=1) and back to IDLE.
    task automatic finish_trap(input string nm, input logic [63:0] epc,
                               input logic [63:0] cause, input logic [63:0] pc);
        @(negedge clk); clear_inputs(); redirect_ready = 1'b1; #1;
        chk({nm, ".save_twe"}, 64'(trap_we), 64'd1);
        chk({nm, ".save_epc"}, trap_epc, epc);
        chk({nm, ".save_cause"}, trap_cause, cause);
        chk({nm, ".save_hold"}, 64'(pipe_hold), 64'd1);
        chk({nm, ".save_rv"}, 64'(redirect_valid), 64'd0);
        @(negedge clk); #1;
        chk({nm, ".jump_rv"}, 64'(redirect_valid), 64'd1);
        chk({nm, ".jump_pc"}, redirect_pc, pc);
        chk({nm, ".jump_twe"}, 64'(trap_we), 64'd0);
        chk({nm, ".jump_rwe"}, 64'(ret_we), 64'd0);
        chk({nm, ".jump_hold"}, 64'(pipe_hold), 64'd1);
        @(negedge clk); #1;
        chk({nm, ".idle_hold"}, 64'(pipe_hold), 64'd0);
        chk({nm, ".idle_rv"}, 64'(redirect_valid), 64'd0);
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        inst_valid = v.valid; inst_ecall = v.ecall; inst_ebreak = v.ebreak; inst_mret = v.mret;
        clint_mtip = v.mtip; mstatus_mie = v.mie; mie_mtie = v.mtie;
        inst_addr = v.addr; mtvec_in = v.mtvec; mepc_in = v.mepc;
        bus_busy = 1'b0; redirect_ready = 1'b1;
        #1;
        chk({v.nm, ".kill"}, 64'(inst_kill), 64'(v.kill));
        chk({v.nm, ".hold0"}, 64'(pipe_hold), 64'd0);
        if (v.kind == 1) begin
            finish_trap(v.nm, v.addr, v.cause, v.pc);
        end else if (v.kind == 2) begin
            @(negedge clk); clear_inputs(); #1;
            chk({v.nm, ".jump_rv"}, 64'(redirect_valid), 64'd1);
            chk({v.nm, ".jump_pc"}, redirect_pc, v.pc);
            chk({v.nm, ".jump_rwe"}, 64'(ret_we), 64'd1);
            chk({v.nm, ".jump_twe"}, 64'(trap_we), 64'd0);
            @(negedge clk); #1;
            chk({v.nm, ".idle_rv"}, 64'(redirect_valid), 64'd0);
            chk({v.nm, ".idle_rwe"}, 64'(ret_we), 64'd0);
        end else begin
            @(negedge clk); clear_inputs(); #1;
            chk({v.nm, ".none_hold"}, 64'(pipe_hold), 64'd0);
            chk({v.nm, ".none_twe"}, 64'(trap_we), 64'd0);
        end
    endtask

    initial begin
        vecs[0] = '{"ecall", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                    64'h8000_0100, 64'h8000_0400, 64'h0, 1'b1, 1, 64'd11, 64'h8000_0400};
        vecs[1] = '{"timer_vec", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1,
                    64'h8000_0200, 64'h8000_0401, 64'h0, 1'b1, 1, IRQ, 64'h8000_041C};
        vecs[2] = '{"timer_mie0", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1,
                    64'h8000_0204, 64'h8000_0401, 64'h0, 1'b0, 0, 64'h0, 64'h0};
        vecs[3] = '{"ebreak_vecmode", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                    64'h8000_0300, 64'h8000_0401, 64'h0, 1'b1, 1, 64'd3, 64'h8000_0400};
        vecs[4] = '{"ecall_plus_irq", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1,
                    64'h8000_0308, 64'h8000_0401, 64'h0, 1'b1, 1, IRQ, 64'h8000_041C};
        vecs[5] = '{"mret", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                    64'h8000_0500, 64'h8000_0400, 64'h8000_0104, 1'b0, 2, 64'h0, 64'h8000_0104};
        vecs[6] = '{"ecall_no_valid", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1,
                    64'h8000_0600, 64'h8000_0400, 64'h0, 1'b0, 0, 64'h0, 64'h0};
        vecs[7] = '{"ecall_mode3", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0,
                    64'h8000_0700, 64'h8000_0003, 64'h0, 1'b1, 1, 64'd11, 64'h8000_0000};
        vecs[8] = '{"mret_plus_irq", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1,
                    64'h8000_0800, 64'h8000_0400, 64'h8000_0104, 1'b1, 1, IRQ, 64'h8000_0400};

        rst = 1'b0; clear_inputs();
        inst_addr = '0; mtvec_in = '0; mepc_in = '0; bus_busy = 1'b0; redirect_ready = 1'b0;
        @(negedge clk); @(negedge clk); #1;
        chk_all_zero("reset");
        rst = 1'b1;

        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // ebreak while a data transaction is outstanding for three cycles
        @(negedge clk);
        inst_valid = 1'b1; inst_ebreak = 1'b1; inst_addr = 64'h8000_0900;
        mtvec_in = 64'h8000_0400; bus_busy = 1'b1; redirect_ready = 1'b1; #1;
        chk("drain.kill", 64'(inst_kill), 64'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); clear_inputs();
            if (k == 2) bus_busy = 1'b0;
            #1;
            chk("drain.twe", 64'(trap_we), 64'd0);
            chk("drain.hold", 64'(pipe_hold), 64'd1);
        end
        finish_trap("drain", 64'h8000_0900, 64'd3, 64'h8000_0400);

        // mret with fetch stalling two cycles
        @(negedge clk);
        inst_valid = 1'b1; inst_mret = 1'b1; inst_addr = 64'h8000_0a00;
        mepc_in = 64'h8000_0104; redirect_ready = 1'b0; #1;
        chk("mret_wait.kill", 64'(inst_kill), 64'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); clear_inputs();
            if (k == 2) redirect_ready = 1'b1;
            #1;
            chk("mret_wait.rv", 64'(redirect_valid), 64'd1);
            chk("mret_wait.pc", redirect_pc, 64'h8000_0104);
            chk("mret_wait.rwe", 64'(ret_we), (k == 2) ? 64'd1 : 64'd0);
        end
        @(negedge clk); #1;
        chk("mret_wait.idle_rwe", 64'(ret_we), 64'd0);
        chk("mret_wait.idle_rv", 64'(redirect_valid), 64'd0);

        // reset while draining
        @(negedge clk);
        inst_valid = 1'b1; inst_ecall = 1'b1; inst_addr = 64'h8000_0b00; bus_busy = 1'b1; #1;
        @(negedge clk); clear_inputs(); #1;
        chk("rst_drain.hold", 64'(pipe_hold), 64'd1);
        rst = 1'b0;
        @(negedge clk); #1;
        chk_all_zero("rst_drain");
        rst = 1'b1; bus_busy = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            chk("rst_drain.after_twe", 64'(trap_we), 64'd0);
            chk("rst_drain.after_hold", 64'(pipe_hold), 64'd0);
        end

        // reset while waiting in JUMP on an mret
        @(negedge clk);
        inst_valid = 1'b1; inst_mret = 1'b1; mepc_in = 64'h8000_0104; redirect_ready = 1'b0; #1;
        @(negedge clk); clear_inputs(); #1;
        chk("rst_jump.rv", 64'(redirect_valid), 64'd1);
        rst = 1'b0;
        @(negedge clk); #1;
        chk_all_zero("rst_jump");
        rst = 1'b1; redirect_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            chk("rst_jump.after_rwe", 64'(ret_we), 64'd0);
            chk("rst_jump.after_rv", 64'(redirect_valid), 64'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/trap_sequencer.md
# trap_sequencer

Machine-mode trap sequencer sitting between the commit stage, the CSR file and instruction fetch. It watches committing instructions and the CLINT timer line, and arbitrates timer interrupt, ecall/ebreak and mret. It then sequences the CSR side effects (mepc/mcause/mstatus updates) and the PC redirect to fetch, holding the pipeline until fetch accepts the new PC.

## Interface
Parameters:
- DATA_W, 64, CSR/data width.
- ADDR_W, 64, instruction address width.

Ports:
- clk  in  1  sole clock; all state changes on rising edge.
- rst  in  1  reset; synchronous, active-low (rst==0 at a clk edge resets).
- inst_valid  in  1  an instruction is at commit this cycle.
- inst_addr  in  ADDR_W  PC of the committing instruction.
- inst_ecall / inst_ebreak / inst_mret  in  1 each  decode flags of the committing instruction (at most one set).
- clint_mtip  in  1  timer interrupt pending (level).
- mstatus_mie  in  1  current mstatus.MIE.
- mie_mtie  in  1  current mie.MTIE.
- mtvec_in  in  DATA_W  current mtvec.
- mepc_in  in  ADDR_W  current mepc.
- bus_busy  in  1  data-side AXI transaction outstanding.
- redirect_ready  in  1  fetch accepts redirect.
- inst_kill  out  1  suppress commit of the current instruction (combinational, IDLE only).
- pipe_hold  out  1  stall commit/fetch.
- trap_we  out  1  one-cycle strobe: CSR file takes trap entry.
- trap_epc  out  ADDR_W  value for mepc.
- trap_cause  out  DATA_W  value for mcause.
- ret_we  out  1  one-cycle strobe: CSR file performs mret update.
- redirect_valid  out  1  new PC offered to fetch.
- redirect_pc  out  ADDR_W  new PC.

## Operation
- States: IDLE, DRAIN, SAVE, JUMP. Internal registers: epc_r, cause_r, is_ret_r.
- Event detection in IDLE, only when inst_valid=1, in priority order:
  1. Interrupt: clint_mtip & mstatus_mie & mie_mtie. cause = 0x8000_0000_0000_0007, epc = inst_addr. The instruction is not executed (inst_kill=1).
  2. ecall: cause=11. ebreak: cause=3. epc=inst_addr, inst_kill=1.
  3. mret: is_ret_r=1, inst_kill=0 (instruction commits normally).
- IDLE transitions:
  - Trap: to DRAIN if bus_busy=1, else SAVE.
  - mret: to JUMP.
  - No event: stay.
- DRAIN: wait until bus_busy=0, then go to SAVE.
- SAVE: trap_we=1, trap_epc=epc_r, trap_cause=cause_r for exactly this cycle; go to JUMP.
- JUMP:
  - redirect_valid=1.
  - Trap: redirect_pc = mtvec_in & ~3 (direct mode, mtvec_in[1:0]!=1). In vectored mode (mtvec_in[1:0]==1) with an interrupt cause: (mtvec_in & ~3) + 4*cause[5:0], i.e. base+0x1C for the timer. Exceptions always use the base.
  - mret: redirect_pc = mepc_in; ret_we=1 in the same cycle redirect_ready is sampled high.
  - Leave to IDLE when redirect_ready=1. redirect_valid, redirect_pc and is_ret_r are stable while waiting.
- pipe_hold=1 in every non-IDLE state. inst_valid, clint_mtip and flags are ignored outside IDLE; no nesting.
- Outside their stated cycles, trap_we/ret_we/redirect_valid are 0 and trap_epc/trap_cause/redirect_pc are 0.
- mtvec_in/mepc_in are sampled in JUMP. The CSR file has already applied trap_we by then; the block relies on the CSR file not changing them while held.

## Timing
- Reset: state=IDLE, epc_r=0, cause_r=0, is_ret_r=0. Every output is 0 in the cycle after a reset edge. Reset in any state aborts the sequence with no further strobes.
- Trap, bus idle: event cycle T (IDLE, inst_kill=1) → T+1 SAVE (trap_we) → T+2 JUMP (redirect_valid) → IDLE at T+3 if redirect_ready at T+2.
- Each DRAIN cycle adds one cycle before SAVE. bus_busy dropping at cycle D gives SAVE at D+1.
- mret: T (IDLE) → T+1 JUMP (redirect_valid, ret_we if ready) → IDLE at T+2.
- Each cycle of redirect_ready=0 in JUMP extends JUMP by one cycle. ret_we asserts only in the accepting cycle, exactly once.
- Interrupt and ecall in the same cycle: interrupt wins, cause=0x8000_0000_0000_0007, ecall is discarded (re-executes after mret).
- clint_mtip dropping after the event cycle does not cancel the sequence.

## Test plan
- ecall at inst_addr=0x8000_0100, bus idle, mtvec_in=0x8000_0400, ready=1 → inst_kill at T; trap_we at T+1 with epc 0x8000_0100, cause 11; redirect 0x8000_0400 at T+2; pipe_hold T+1..T+2.
- Timer: mtip=1, MIE=1, MTIE=1, mtvec_in=0x8000_0401, ready=1 → cause 0x8000_0000_0000_0007; redirect 0x8000_041C. Repeat with MIE=0 → no event, inst_kill=0.
- ebreak with bus_busy high for 3 cycles → 3 DRAIN cycles; trap_we only after bus_busy=0; cause 3.
- mret with mepc_in=0x8000_0104 and redirect_ready low 2 cycles → redirect_valid held 3 cycles, pc stable; ret_we exactly once, in the accepting cycle; inst_kill=0.
- ecall and timer interrupt same cycle → single trap, cause 0x8000_0000_0000_0007, one trap_we.
- rst driven low during DRAIN and again during JUMP → IDLE next edge; all outputs 0; no trap_we/ret_we emitted afterwards.
